// File: rtl/axi_write_adapter_if.sv
// Bus bundle for the MEM-stage store adapter: the AXI3 AW/W/B channels plus the
// MEM-side store request, with one modport per side.
interface axi_write_adapter_if;
  // AXI write address channel
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  // AXI write data channel
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  // AXI write response channel
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  // MEM-stage store request
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_sel;
  logic        mem_write_done;
  logic        mem_write_err;
  logic        mem_busy;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    input  mem_we, mem_addr, mem_wdata, mem_sel,
    output mem_write_done, mem_write_err, mem_busy
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    output mem_we, mem_addr, mem_wdata, mem_sel,
    input  mem_write_done, mem_write_err, mem_busy
  );
endinterface

// File: rtl/axi_write_adapter.sv
// Single-beat AXI3 write master for the MEM-stage store path: one store in flight,
// AW and W issued together and retired independently, then a one-cycle done pulse.
module axi_write_adapter (
  input  logic                 i_clk,
  input  logic                 i_reset,
  axi_write_adapter_if.master  bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEND   = 2'd1;
  localparam logic [1:0] WAIT_B = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]  r_state;
  logic        r_awvalid;
  logic        r_wvalid;
  logic        r_aw_done;
  logic        r_w_done;
  logic [31:0] r_awaddr;
  logic [2:0]  r_awsize;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_err;

  logic        w_aw_fire;
  logic        w_w_fire;
  logic        w_aw_now;
  logic        w_w_now;
  logic [2:0]  w_sel_cnt;
  logic [2:0]  w_size;
  logic [31:0] w_phys_addr;
  logic        w_unused;

  assign w_aw_fire = r_awvalid & bus.awready;
  assign w_w_fire  = r_wvalid & bus.wready;
  // Handshakes on the current edge count toward leaving SEND on that same edge.
  assign w_aw_now  = r_aw_done | w_aw_fire;
  assign w_w_now   = r_w_done | w_w_fire;

  assign w_sel_cnt = {2'b00, bus.mem_sel[0]} + {2'b00, bus.mem_sel[1]}
                   + {2'b00, bus.mem_sel[2]} + {2'b00, bus.mem_sel[3]};

  always_comb begin
    w_size = 3'b010;
    case (w_sel_cnt)
      3'd1:    w_size = 3'b000;
      3'd2:    w_size = 3'b001;
      default: w_size = 3'b010;
    endcase
  end

  // Segments at 0x8000_0000 and 0xA000_0000 both alias physical address 0.
  always_comb begin
    w_phys_addr = bus.mem_addr;
    if (bus.mem_addr[31:30] == 2'b10)
      w_phys_addr = {3'b000, bus.mem_addr[28:0]};
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_awaddr  <= '0;
      r_awsize  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.mem_we) begin
            r_awaddr  <= w_phys_addr;
            r_awsize  <= w_size;
            r_wdata   <= bus.mem_wdata;
            r_wstrb   <= bus.mem_sel;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_state   <= SEND;
          end
        end
        SEND: begin
          if (w_aw_fire) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_fire) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_now && w_w_now)
            r_state <= WAIT_B;
        end
        WAIT_B: begin
          if (bus.bvalid) begin
            r_err   <= (bus.bresp != 2'b00);
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.awid    = 4'd0;
  assign bus.awlen   = 4'd0;
  assign bus.awburst = 2'd0;
  assign bus.awlock  = 2'd0;
  assign bus.awcache = 4'd0;
  assign bus.awprot  = 3'b001;
  assign bus.awaddr  = r_awaddr;
  assign bus.awsize  = r_awsize;
  assign bus.awvalid = r_awvalid;

  assign bus.wid     = 4'd0;
  assign bus.wdata   = r_wdata;
  assign bus.wstrb   = r_wstrb;
  assign bus.wvalid  = r_wvalid;
  assign bus.wlast   = r_wvalid;

  assign bus.bready         = (r_state == WAIT_B);
  assign bus.mem_write_done = (r_state == DONE);
  assign bus.mem_write_err  = (r_state == DONE) & r_err;
  assign bus.mem_busy       = (r_state != IDLE);

  // Response ID carries no information for a single-outstanding master.
  assign w_unused = ^bus.bid;

endmodule
